mmio_uart: RTL and testbench

Memory-mapped UART responder on the CPU's external data bus. It decodes `addr`/`we`/`re` cycles the CPU issues when `addr[15:12]` is nonzero, returns read data on `rdata`, and serialises/deserialises 8N1 bytes through 8-entry TX and RX FIFOs. It sits beside the CPU at the top level, outside the core's internal data memory space.

---
 rtl/mmio_uart.sv | 192 +++++++++++++++++++
 tb/tb_mmio_uart.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mmio_uart.sv
// mmio_uart: memory-mapped 8N1 UART with 8-entry TX/RX FIFOs and a programmable baud divisor.
// Optional feature macro: MMIO_UART_LOOPBACK_EN (STATUS[13] loopback of txd into the receiver).
module mmio_uart #(
    parameter logic [15:0] BASE      = 16'hC000,
    parameter logic [15:0] DIV_RESET = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [15:0] rdata,
    output logic        txd,
    input  logic        rxd
);
    localparam int unsigned PW = 3;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic          sel_data, sel_stat, sel_div, rd_only;
    logic          tx_push, tx_pop, rx_push, rx_push_ok, rx_pop, ovr_set, stat_clr;
    logic [7:0]    tx_mem [8];
    logic [7:0]    rx_mem [8];
    logic [PW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CW-1:0] tx_cnt_q, rx_cnt_q;
    logic [15:0]   div_q;
    logic          ovr_q, loop_en, rx_in;
    state_t        tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [15:0]   tx_tmr_q, tx_tmr_d, tx_div_q, tx_div_d;
    logic [15:0]   rx_tmr_q, rx_tmr_d, rx_div_q, rx_div_d;
    logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic          txd_q, txd_d, sync1_q, sync2_q, sync3_q;

    assign sel_data   = (addr == BASE);
    assign sel_stat   = (addr == BASE + 16'd1);
    assign sel_div    = (addr == BASE + 16'd2);
    assign rd_only    = re && !we;
    assign tx_push    = we && sel_data && (tx_cnt_q != CW'(8));
    assign rx_pop     = rd_only && sel_data && (rx_cnt_q != CW'(0));
    assign stat_clr   = rd_only && sel_stat;
    assign rx_push_ok = rx_push && ((rx_cnt_q != CW'(8)) || rx_pop);
    assign ovr_set    = rx_push && (rx_cnt_q == CW'(8)) && !rx_pop;

`ifdef MMIO_UART_LOOPBACK_EN
    logic lb_q;
    // Loopback enable, the only writable STATUS bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 lb_q <= 1'b0;
        else if (we && sel_stat) lb_q <= wdata[13];
    end
    assign loop_en = lb_q;
    assign rx_in   = lb_q ? txd_q : rxd;
    assign txd     = lb_q ? 1'b1 : txd_q;
`else
    assign loop_en = 1'b0;
    assign rx_in   = rxd;
    assign txd     = txd_q;
`endif

    // FIFO storage; contents need no reset since counts gate visibility
    always_ff @(posedge clk) begin
        if (tx_push)    tx_mem[tx_wp_q] <= wdata[7:0];
        if (rx_push_ok) rx_mem[rx_wp_q] <= rx_sh_q;
    end

    // FIFO pointers/counts, divisor, overrun flag, synchroniser
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
            rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
            div_q   <= DIV_RESET;
            ovr_q   <= 1'b0;
            sync1_q <= 1'b1; sync2_q <= 1'b1; sync3_q <= 1'b1;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + PW'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + PW'(1);
            if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + CW'(1);
            else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CW'(1);
            if (rx_push_ok) rx_wp_q <= rx_wp_q + PW'(1);
            if (rx_pop)     rx_rp_q <= rx_rp_q + PW'(1);
            if (rx_push_ok && !rx_pop)      rx_cnt_q <= rx_cnt_q + CW'(1);
            else if (!rx_push_ok && rx_pop) rx_cnt_q <= rx_cnt_q - CW'(1);
            if (we && sel_div) div_q <= (wdata < 16'd2) ? 16'd2 : wdata;
            if (ovr_set)       ovr_q <= 1'b1;
            else if (stat_clr) ovr_q <= 1'b0;
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // FSM state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st_q <= S_IDLE; tx_tmr_q <= '0; tx_div_q <= DIV_RESET;
            tx_bit_q <= '0; tx_sh_q <= '0; txd_q <= 1'b1;
            rx_st_q <= S_IDLE; rx_tmr_q <= '0; rx_div_q <= DIV_RESET;
            rx_bit_q <= '0; rx_sh_q <= '0;
        end else begin
            tx_st_q <= tx_st_d; tx_tmr_q <= tx_tmr_d; tx_div_q <= tx_div_d;
            tx_bit_q <= tx_bit_d; tx_sh_q <= tx_sh_d; txd_q <= txd_d;
            rx_st_q <= rx_st_d; rx_tmr_q <= rx_tmr_d; rx_div_q <= rx_div_d;
            rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d;
        end
    end

    // TX next state: txd_d is the line value for the state being entered
    always_comb begin
        logic tx_end, tx_load;
        tx_st_d = tx_st_q; tx_tmr_d = tx_tmr_q + 16'd1; tx_div_d = tx_div_q;
        tx_bit_d = tx_bit_q; tx_sh_d = tx_sh_q; txd_d = txd_q;
        tx_pop  = 1'b0;
        tx_load = 1'b0;
        tx_end  = (tx_tmr_q == tx_div_q - 16'd1);
        case (tx_st_q)
            S_IDLE: begin
                tx_tmr_d = '0;
                txd_d    = 1'b1;
                tx_load  = (tx_cnt_q != CW'(0));
            end
            S_START: if (tx_end) begin
                tx_st_d = S_DATA; tx_tmr_d = '0; tx_bit_d = '0; txd_d = tx_sh_q[0];
            end
            S_DATA: if (tx_end) begin
                tx_tmr_d = '0;
                if (tx_bit_q == 3'd7) begin
                    tx_st_d = S_STOP; txd_d = 1'b1;
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    tx_sh_d  = tx_sh_q >> 1;
                    txd_d    = tx_sh_q[1];
                end
            end
            S_STOP: if (tx_end) begin
                tx_st_d = S_IDLE; tx_tmr_d = '0; txd_d = 1'b1;
                tx_load = (tx_cnt_q != CW'(0));
            end
            default: tx_st_d = S_IDLE;
        endcase
        if (tx_load) begin
            tx_pop = 1'b1; tx_st_d = S_START; tx_tmr_d = '0;
            tx_sh_d = tx_mem[tx_rp_q]; tx_div_d = div_q; txd_d = 1'b0;
        end
    end

    // RX next state: mid-bit sampling of the synchronised line
    always_comb begin
        logic rx_end;
        rx_st_d = rx_st_q; rx_tmr_d = rx_tmr_q + 16'd1; rx_div_d = rx_div_q;
        rx_bit_d = rx_bit_q; rx_sh_d = rx_sh_q;
        rx_push = 1'b0;
        rx_end  = (rx_tmr_q == rx_div_q - 16'd1);
        case (rx_st_q)
            S_IDLE: begin
                rx_tmr_d = '0;
                if (sync3_q && !sync2_q) begin
                    rx_st_d = S_START; rx_div_d = div_q;
                end
            end
            S_START: if (rx_tmr_q == (rx_div_q >> 1) - 16'd1) begin
                rx_tmr_d = '0; rx_bit_d = '0;
                rx_st_d  = sync2_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_end) begin
                rx_tmr_d = '0;
                rx_sh_d  = {sync2_q, rx_sh_q[7:1]};
                if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
                else                  rx_bit_d = rx_bit_q + 3'd1;
            end
            S_STOP: if (rx_end) begin
                rx_tmr_d = '0; rx_st_d = S_IDLE; rx_push = sync2_q;
            end
            default: rx_st_d = S_IDLE;
        endcase
    end

    // Combinational read mux
    always_comb begin
        logic [15:0] status;
        status = {ovr_q, (tx_st_q != S_IDLE) || (tx_cnt_q != CW'(0)), loop_en, 5'b0,
                  CW'(8) - tx_cnt_q, rx_cnt_q};
        rdata  = '0;
        if (re) begin
            if (sel_data && (rx_cnt_q != CW'(0))) rdata = {8'h00, rx_mem[rx_rp_q]};
            else if (sel_stat)                    rdata = status;
            else if (sel_div)                     rdata = div_q;
        end
    end
endmodule

// File: tb/tb_mmio_uart.sv
// Directed self-checking bench for mmio_uart (default build, loopback disabled).
module tb_mmio_uart;
    localparam logic [15:0] BASE = 16'hC000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr, wdata, rdata;
    logic        we, re, txd, rxd;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] rd;
    logic        line [200];
    logic [9:0]  fr;
    logic [9:0]  got;

    mmio_uart #(.BASE(BASE), .DIV_RESET(16'd434)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0; addr = '0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        addr = a; re = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        re = 1'b0; addr = '0;
    endtask

    task automatic send_frame(input logic [7:0] b, input int bc);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (bc) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0; rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and decode
        bus_read(BASE + 16'd1, rd); check("reset_status", rd, 16'h0080);
        bus_read(BASE + 16'd2, rd); check("reset_div", rd, 16'd434);
        check("reset_txd", 16'(txd), 16'h0001);
        bus_read(BASE + 16'd3, rd); check("unmapped_read", rd, 16'h0000);
        bus_read(16'h0001, rd);     check("low_nibble_read", rd, 16'h0000);
        @(negedge clk); addr = BASE + 16'd1; re = 1'b0;
        #1 check("re_low_rdata", rdata, 16'h0000);

        // TX of 0xA5 with DIV=4
        bus_write(BASE + 16'd2, 16'd4);
        bus_write(BASE, 16'h00A5);
        check("tx_pre_start", 16'(txd), 16'h0001);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int j = 1; j <= 41; j++) begin
            @(negedge clk);
            if (j == 1) check("tx_start_edge", 16'(txd), 16'h0000);
            if (j >= 2 && j <= 38 && ((j - 2) % 4) == 0)
                check($sformatf("tx_bit%0d", (j - 2) / 4), 16'(txd), 16'(fr[(j - 2) / 4]));
            if (j == 40) begin
                addr = BASE + 16'd1; re = 1'b1;
                #1 check("tx_busy_last", 16'(rdata[14]), 16'h0001);
            end
            if (j == 41) begin
                #1 check("tx_idle_after40", 16'(rdata[14]), 16'h0000);
                re = 1'b0; addr = '0;
            end
        end

        // RX of 0x3C with DIV=4
        @(negedge clk);
        send_frame(8'h3C, 4);
        repeat (2) @(negedge clk);
        bus_read(BASE + 16'd1, rd); check("rx_status_one", rd, 16'h0081);
        bus_read(BASE, rd);         check("rx_data", rd, 16'h003C);
        bus_read(BASE + 16'd1, rd); check("rx_status_empty", rd, 16'h0080);

        // 9 frames: overrun, then in-order reads across pointer wrap
        for (int i = 0; i < 9; i++) send_frame(8'h11 + 8'(i), 4);
        repeat (2) @(negedge clk);
        bus_read(BASE + 16'd1, rd); check("rx_overrun_status", rd, 16'h8088);
        for (int i = 0; i < 8; i++) begin
            bus_read(BASE, rd);
            check($sformatf("rx_fifo%0d", i), rd, 16'h0011 + 16'(i));
        end
        bus_read(BASE + 16'd1, rd); check("rx_drained_status", rd, 16'h0080);

        // 10 back-to-back writes with DIV=2: 9 accepted, contiguous frames
        bus_write(BASE + 16'd2, 16'd2);
        for (int k = 0; k < 190; k++) begin
            @(negedge clk);
            if (k < 10) begin
                we = 1'b1; addr = BASE; wdata = 16'(k + 1);
            end else if (k == 10) begin
                we = 1'b0; re = 1'b1; addr = BASE + 16'd1;
                #1 check("tx_full_status", rdata, 16'h4000);
            end else begin
                re = 1'b0; addr = '0;
            end
            line[k] = txd;
        end
        for (int f = 0; f < 9; f++) begin
            for (int b = 0; b < 10; b++) got[b] = line[2 + 20 * f + 2 * b];
            check($sformatf("tx_frame%0d", f), 16'(got), 16'({1'b1, 8'(f + 1), 1'b0}));
        end
        check("tx_idle_after9", 16'(line[183]), 16'h0001);
        bus_read(BASE + 16'd1, rd); check("tx_done_status", rd, 16'h0080);

        // DIV clamp and async reset mid-frame
        bus_write(BASE + 16'd2, 16'd0);
        bus_read(BASE + 16'd2, rd); check("div_clamp", rd, 16'd2);
        bus_write(BASE, 16'h0000);
        repeat (3) @(negedge clk);
        check("tx_mid_frame_low", 16'(txd), 16'h0000);
        #2 rst = 1'b1;
        #1 check("tx_async_reset", 16'(txd), 16'h0001);
        @(negedge clk); rst = 1'b0;
        bus_read(BASE + 16'd1, rd); check("post_reset_status", rd, 16'h0080);
        bus_read(BASE + 16'd2, rd); check("post_reset_div", rd, 16'd434);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
